// File: rtl/skew_feeder_pkg.sv
// Shared definitions for the skew_feeder block: FSM state encoding and
// default configuration constants for the array size, operand width and
// drain length.
package skew_feeder_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FEED  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Default array dimension (rows = columns = lanes).
  localparam int N_DEFAULT = 2;

  // Default signed operand width.
  localparam int DW_DEFAULT = 16;

  // The drain defaults to two cycles per lane so the last skewed operands
  // have time to ripple through an N x N array before done is raised.
  localparam int DRAIN_PER_LANE = 2;

endpackage

// File: rtl/skew_feeder_skew_lane_mux.sv
// skew_lane_mux: picks the operand one systolic lane must see in a given
// feed cycle. Lane LANE receives element (t - LANE) of its stored vector,
// or zero when that index falls outside 0..N-1. Purely combinational; the
// caller registers the result.
module skew_lane_mux #(
  parameter int N    = 2,
  parameter int DW   = 16,
  parameter int LANE = 0,
  parameter int IDXW = 2
) (
  input  logic [N*DW-1:0] vec,
  input  logic [IDXW-1:0] t,
  output logic [DW-1:0]   sel
);

  // Select the element whose skewed slot lines up with feed index t.
  always_comb begin
    sel = '0;
    for (int c = 0; c < N; c++) begin
      if (int'(t) == c + LANE) begin
        sel = vec[c*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/skew_feeder.sv
// skew_feeder: collects an N x N operand pair (A by rows, B by columns) as
// N load beats, then streams them out diagonally skewed for a systolic
// array over 2N-1 feed cycles, waits DRAIN_CYC cycles and pulses done.
// Optional feature macro: SKEW_FEEDER_PERF_EN adds a 32-bit saturating
// busy-cycle counter on output perf_cycles.
module skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter int DW        = DW_DEFAULT,
  parameter int DRAIN_CYC = DRAIN_PER_LANE * N
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_a,
  input  logic [N*DW-1:0] in_b,
  output logic            out_valid,
  output logic [N*DW-1:0] a_out,
  output logic [N*DW-1:0] b_out,
  output logic            busy,
  output logic            done
`ifdef SKEW_FEEDER_PERF_EN
  ,
  output logic [31:0]     perf_cycles
`endif
);

  // Counter widths: beat index 0..N-1, feed index 0..2N-2, drain 0..DRAIN_CYC-1.
  localparam int BW   = (N > 1) ? $clog2(N) : 1;
  localparam int IDXW = $clog2(2*N - 1);
  localparam int DCW  = $clog2(DRAIN_CYC + 1);

  localparam logic [BW-1:0]   BEAT_LAST = BW'(N - 1);
  localparam logic [IDXW-1:0] T_LAST    = IDXW'(2*N - 2);
  localparam logic [DCW-1:0]  D_LAST    = DCW'(DRAIN_CYC - 1);

  state_e state_q, state_d;

  logic [BW-1:0]   beat_q, beat_d;
  logic [IDXW-1:0] t_q, t_d;
  logic [DCW-1:0]  drain_q, drain_d;

  // Operand storage: a_rows[k] is row k of A, b_cols[k] is column k of B.
  // Kept in flops because every lane reads a different element each cycle.
  logic [N*DW-1:0] a_rows_q [N];
  logic [N*DW-1:0] a_rows_d [N];
  logic [N*DW-1:0] b_cols_q [N];
  logic [N*DW-1:0] b_cols_d [N];

  logic            out_valid_q, out_valid_d;
  logic [N*DW-1:0] a_out_q, a_out_d;
  logic [N*DW-1:0] b_out_q, b_out_d;

  logic [DW-1:0]   a_lane [N];
  logic [DW-1:0]   b_lane [N];

  logic            accept;

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DRAIN) && (drain_q == D_LAST);
  assign accept    = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign a_out     = a_out_q;
  assign b_out     = b_out_q;

  // Next-state logic: beat capture, feed indexing and drain timing.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    t_d     = t_q;
    drain_d = drain_q;
    for (int k = 0; k < N; k++) begin
      a_rows_d[k] = a_rows_q[k];
      b_cols_d[k] = b_cols_q[k];
    end

    // Store the accepted beat into slot beat_q regardless of state; accept
    // can only be high in IDLE or LOAD.
    for (int k = 0; k < N; k++) begin
      if (accept && (beat_q == BW'(k))) begin
        a_rows_d[k] = in_a;
        b_cols_d[k] = in_b;
      end
    end

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            t_d     = '0;
            state_d = ST_FEED;
          end else begin
            beat_d  = beat_q + BW'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_FEED: begin
        if (t_q == T_LAST) begin
          t_d     = '0;
          drain_d = '0;
          state_d = ST_DRAIN;
        end else begin
          t_d = t_q + IDXW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == D_LAST) begin
          drain_d = '0;
          state_d = ST_IDLE;
        end else begin
          drain_d = drain_q + DCW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // One lane mux per array row (A) and per array column (B). They look at
  // the next-cycle storage and index so the outputs can be registered and
  // still line up with the FEED cycle they belong to.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    skew_lane_mux #(
      .N    (N),
      .DW   (DW),
      .LANE (gi),
      .IDXW (IDXW)
    ) u_a_mux (
      .vec (a_rows_d[gi]),
      .t   (t_d),
      .sel (a_lane[gi])
    );

    skew_lane_mux #(
      .N    (N),
      .DW   (DW),
      .LANE (gi),
      .IDXW (IDXW)
    ) u_b_mux (
      .vec (b_cols_d[gi]),
      .t   (t_d),
      .sel (b_lane[gi])
    );
  end

  // Output staging: lanes are forced to zero outside FEED.
  always_comb begin
    out_valid_d = (state_d == ST_FEED);
    a_out_d     = '0;
    b_out_d     = '0;
    for (int i = 0; i < N; i++) begin
      if (out_valid_d) begin
        a_out_d[i*DW +: DW] = a_lane[i];
        b_out_d[i*DW +: DW] = b_lane[i];
      end
    end
  end

  // State, counters, operand storage and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      t_q         <= '0;
      drain_q     <= '0;
      out_valid_q <= 1'b0;
      a_out_q     <= '0;
      b_out_q     <= '0;
      for (int k = 0; k < N; k++) begin
        a_rows_q[k] <= '0;
        b_cols_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      t_q         <= t_d;
      drain_q     <= drain_d;
      out_valid_q <= out_valid_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      for (int k = 0; k < N; k++) begin
        a_rows_q[k] <= a_rows_d[k];
        b_cols_q[k] <= b_cols_d[k];
      end
    end
  end

`ifdef SKEW_FEEDER_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Busy-cycle counter, saturating at all-ones.
  always_comb begin
    perf_d = perf_q;
    if (busy && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Perf counter register; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_skew_feeder.sv
// Self-checking bench for skew_feeder (N=2, DW=16, DRAIN_CYC=4).
// Expected feed cycles are queued when a job is loaded and popped by a
// monitor whenever out_valid is seen.
module tb_skew_feeder;

  localparam int N  = 2;
  localparam int DW = 16;
  localparam int DC = 4;

  typedef logic [N-1:0][N*DW-1:0] beats_t;
  typedef struct packed {
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] b;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_a;
  logic [N*DW-1:0] in_b;
  logic            out_valid;
  logic [N*DW-1:0] a_out;
  logic [N*DW-1:0] b_out;
  logic            busy;
  logic            done;
`ifdef SKEW_FEEDER_PERF_EN
  logic [31:0]     perf_cycles;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  bit   mon_en   = 1'b0;
  exp_t exp_q[$];

  skew_feeder #(
    .N         (N),
    .DW        (DW),
    .DRAIN_CYC (DC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .a_out     (a_out),
    .b_out     (b_out),
    .busy      (busy),
    .done      (done)
`ifdef SKEW_FEEDER_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] pk(input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    return {e1, e0};
  endfunction

  // Reference skew: lane i in cycle t carries element t-i of vector i
  // (row i of A, column i of B), zero outside the matrix.
  task automatic push_model(input beats_t ba, input beats_t bb);
    exp_t e;
    for (int t = 0; t < 2*N-1; t++) begin
      e = '0;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i < N) begin
          e.a[i*DW +: DW] = ba[i][(t-i)*DW +: DW];
          e.b[i*DW +: DW] = bb[i][(t-i)*DW +: DW];
        end
      end
      exp_q.push_back(e);
    end
  endtask

  // Hand-computed feed for the basic job A rows (1,2),(3,4), B cols (5,7),(6,8).
  task automatic push_basic();
    exp_t e;
    e.a = pk(16'd1, 16'd0); e.b = pk(16'd5, 16'd0); exp_q.push_back(e);
    e.a = pk(16'd2, 16'd3); e.b = pk(16'd7, 16'd6); exp_q.push_back(e);
    e.a = pk(16'd0, 16'd4); e.b = pk(16'd0, 16'd8); exp_q.push_back(e);
  endtask

  // Monitor: scoreboard compare on feed cycles, zero lanes otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_feed", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("a_out", 64'(a_out), 64'(e.a));
          check("b_out", 64'(b_out), 64'(e.b));
        end
      end else begin
        check("idle_lanes_zero", 64'({a_out, b_out}), 64'd0);
      end
      if (done) done_cnt++;
    end
  end

  // Offer one beat and hold it until accepted. Returns the number of
  // cycles in_ready was low; keep leaves in_valid asserted afterwards.
  task automatic send_beat(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                           input bit keep, output int waits);
    bit acc;
    int cyc;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    waits    = 0;
    cyc      = 0;
    acc      = 1'b0;
    while (!acc && cyc < 100) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) waits++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!acc) check("beat_accept_timeout", 64'd0, 64'd1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int  cyc;
    bit  seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      seen = done;
      cyc++;
    end
    check(tag, 64'(seen), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic load_job(input beats_t ba, input beats_t bb, input int gap);
    int w;
    send_beat(ba[0], bb[0], 1'b0, w);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check($sformatf("stall_ready_g%0d", g), 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    send_beat(ba[1], bb[1], 1'b0, w);
  endtask

  initial begin
    beats_t ba, bb, ba2, bb2;
    int     w;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;

    // Reset values while reset is held.
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
`ifdef SKEW_FEEDER_PERF_EN
    check("rst_perf", 64'(perf_cycles), 64'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // Basic feed with full cycle-accurate timing of FEED, DRAIN and done.
    ba[0] = pk(16'd1, 16'd2); ba[1] = pk(16'd3, 16'd4);
    bb[0] = pk(16'd5, 16'd7); bb[1] = pk(16'd6, 16'd8);
    push_basic();
    load_job(ba, bb, 0);
    for (int c = 0; c < 2*N-1; c++) begin
      @(negedge clk);
      check($sformatf("feed_valid_t%0d", c), 64'(out_valid), 64'd1);
      check($sformatf("feed_ready_t%0d", c), 64'(in_ready), 64'd0);
    end
    for (int c = 0; c < DC; c++) begin
      @(negedge clk);
      check($sformatf("drain_valid_%0d", c), 64'(out_valid), 64'd0);
      check($sformatf("drain_busy_%0d", c), 64'(busy), 64'd1);
      check($sformatf("drain_ready_%0d", c), 64'(in_ready), 64'd0);
      check($sformatf("drain_done_%0d", c), 64'(done), 64'(c == DC-1));
    end
    @(negedge clk);
    check("after_done_ready", 64'(in_ready), 64'd1);
    check("after_done_busy", 64'(busy), 64'd0);
    check("after_done_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;

    // Load stall: 5 idle cycles between beats, same expected feed.
    push_basic();
    load_job(ba, bb, 5);
    wait_done("stall_done");

    // Sign and extremes pass through bit-exact.
    ba[0] = pk(16'h8000, 16'h8000); ba[1] = pk(16'h8000, 16'h8000);
    bb[0] = pk(16'h7FFF, 16'h7FFF); bb[1] = pk(16'h7FFF, 16'h7FFF);
    push_model(ba, bb);
    load_job(ba, bb, 0);
    wait_done("extreme_done");

    // Reset during feed cycle t=1 aborts without done.
    ba[0] = pk(16'd11, 16'd12); ba[1] = pk(16'd13, 16'd14);
    bb[0] = pk(16'd15, 16'd16); bb[1] = pk(16'd17, 16'd18);
    push_model(ba, bb);
    load_job(ba, bb, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ba[0] = pk(16'hFFFF, 16'h0002); ba[1] = pk(16'h1234, 16'hFEDC);
    bb[0] = pk(16'h00AA, 16'h8001); bb[1] = pk(16'h7FFE, 16'h0F0F);
    push_model(ba, bb);
    load_job(ba, bb, 0);
    wait_done("fresh_done");

    // Back-to-back jobs with in_valid held high throughout.
    ba2[0] = pk(16'd21, 16'd22); ba2[1] = pk(16'd23, 16'd24);
    bb2[0] = pk(16'd25, 16'd26); bb2[1] = pk(16'd27, 16'd28);
    push_model(ba, bb);
    push_model(ba2, bb2);
    send_beat(ba[0], bb[0], 1'b1, w);
    send_beat(ba[1], bb[1], 1'b1, w);
    send_beat(ba2[0], bb2[0], 1'b1, w);
    check("b2b_wait_cycles", 64'(w), 64'(2*N-1 + DC));
    send_beat(ba2[1], bb2[1], 1'b0, w);
    wait_done("b2b_done");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("done_pulse_count", 64'(done_cnt), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
